// File: rtl/operand_handler_pkg.sv
// Shared encodings for the sequential B-operand handler: operation selects and FSM states.
package operand_handler_pkg;

    localparam logic [2:0] SEL_PASS  = 3'd0;
    localparam logic [2:0] SEL_LSE11 = 3'd1;
    localparam logic [2:0] SEL_LSE14 = 3'd2;
    localparam logic [2:0] SEL_LIMM  = 3'd3;
    localparam logic [2:0] SEL_SRL   = 3'd4;
    localparam logic [2:0] SEL_SRA   = 3'd5;
    localparam logic [2:0] SEL_SLL   = 3'd6;
    localparam logic [2:0] SEL_ZERO  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] sel);
        return (sel == SEL_SRL) || (sel == SEL_SRA) || (sel == SEL_SLL);
    endfunction

endpackage

// File: rtl/operand_step_shifter.sv
// Combinational shifter moving data by 0..STEP bits, left or right with a selectable fill bit.
module operand_step_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 8,
    localparam int unsigned SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SW-1:0]    s,
    input  logic             left,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        // Vacated high bits after a right shift are the ones cleared in the shifted all-ones mask.
        fill_mask = fill ? ~({WIDTH{1'b1}} >> s) : '0;
        if (left) begin
            result = data << s;
        end else begin
            result = (data >> s) | fill_mask;
        end
    end

endmodule

// File: rtl/operand_handler_seq.sv
// Multi-cycle B-operand handler: immediate formatting plus an iterative STEP-bits-per-cycle shifter.
module operand_handler_seq
    import operand_handler_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 21,
    parameter int unsigned STEP  = 8,
    localparam int unsigned AW   = $clog2(WIDTH),
    localparam int unsigned SW   = $clog2(STEP + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rb,
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       sel,
    input  logic             use_sar,
    input  logic [AW-1:0]    sar,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] n,
    output logic             busy
);

    localparam logic [AW:0] STEP_EXT = (AW + 1)'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic             sign_q, sign_d;

    logic             accept;
    logic             load;
    logic [AW-1:0]    field_f;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] imm_result;
    logic [AW:0]      rem_ext;
    logic [SW-1:0]    step_s;
    logic [WIDTH-1:0] shifted;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign n         = data_q;
    assign accept    = in_valid && in_ready;

    // Shift amount counts from the MSB end, so it wraps modulo 2^AW.
    assign field_f = use_sar ? sar : imm[5 +: AW];
    assign amt     = AW'(WIDTH - 1) - field_f;

    always_comb begin
        imm_result = '0;
        unique case (sel)
            SEL_PASS:  imm_result = rb;
            SEL_LSE11: imm_result = {{(WIDTH - 11){imm[10]}}, imm[0], imm[10:1]};
            SEL_LSE14: imm_result = {{(WIDTH - 14){imm[13]}}, imm[0], imm[12:0]};
            SEL_LIMM:  imm_result = WIDTH'(imm) << (WIDTH - IMM_W);
            SEL_SRL,
            SEL_SRA,
            SEL_SLL:   imm_result = rb;
            SEL_ZERO:  imm_result = '0;
            default:   imm_result = '0;
        endcase
    end

    // Per-cycle shift distance is min(rem, STEP); widened so STEP == WIDTH still compares.
    always_comb begin
        rem_ext = {1'b0, rem_q};
        if (rem_ext < STEP_EXT) begin
            step_s = SW'(rem_q);
        end else begin
            step_s = SW'(STEP);
        end
    end

    operand_step_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step_shifter (
        .data   (data_q),
        .s      (step_s),
        .left   (op_q == SEL_SLL),
        .fill   (sign_q && (op_q == SEL_SRA)),
        .result (shifted)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = accept;
            end
            SHIFT: begin
                data_d = shifted;
                rem_d  = rem_q - AW'(step_s);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            op_d = sel;
            if (is_shift(sel) && (amt != '0)) begin
                data_d  = rb;
                rem_d   = amt;
                sign_d  = rb[WIDTH-1];
                state_d = SHIFT;
            end else begin
                data_d  = imm_result;
                rem_d   = '0;
                sign_d  = 1'b0;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= SEL_PASS;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: tb/tb_operand_handler_seq.sv
// Randomised and directed bench for operand_handler_seq against a plain-arithmetic reference model.
module tb_operand_handler_seq;

    localparam int WIDTH = 32;
    localparam int IMM_W = 21;
    localparam int STEP  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rb;
    logic [20:0] imm;
    logic [2:0]  sel;
    logic        use_sar;
    logic [4:0]  sar;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] n;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    operand_handler_seq #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rb        (rb),
        .imm       (imm),
        .sel       (sel),
        .use_sar   (use_sar),
        .sar       (sar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n         (n),
        .busy      (busy)
    );

    function automatic int model_amt(input logic [20:0] im, input logic us, input logic [4:0] sr);
        int f;
        f = us ? int'(sr) : int'(im[9:5]);
        return 31 - f;
    endfunction

    function automatic logic [31:0] model_n(input logic [2:0] s, input logic [31:0] b,
                                            input logic [20:0] im, input logic us,
                                            input logic [4:0] sr);
        int amt;
        logic [31:0] r;
        amt = model_amt(im, us, sr);
        case (s)
            3'd0: r = b;
            3'd1: begin
                r = {21'b0, im[0], im[10:1]};
                if (im[10]) r = r - 32'h800;
            end
            3'd2: begin
                r = {18'b0, im[0], im[12:0]};
                if (im[13]) r = r - 32'h4000;
            end
            3'd3: r = 32'(im) * 32'h800;
            3'd4: r = b >> amt;
            3'd5: r = 32'($signed(b) >>> amt);
            3'd6: r = b << amt;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] s, input logic [20:0] im, input logic us,
                                     input logic [4:0] sr);
        int amt;
        amt = model_amt(im, us, sr);
        if ((s >= 3'd4) && (s <= 3'd6) && (amt > 0)) return (amt + STEP - 1) / STEP;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [31:0] b, input logic [20:0] im,
                         input logic us, input logic [4:0] sr);
        sel      = s;
        rb       = b;
        imm      = im;
        use_sar  = us;
        sar      = sr;
        in_valid = 1'b1;
    endtask

    // Drop the request and garble every field so captured values are what count.
    task automatic scramble();
        in_valid = 1'b0;
        rb       = $urandom;
        imm      = 21'($urandom);
        sel      = 3'($urandom);
        use_sar  = 1'($urandom);
        sar      = 5'($urandom);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < max_cyc) begin
            step();
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rb        = '0;
        imm       = '0;
        sel       = '0;
        use_sar   = 1'b0;
        sar       = '0;
        step();
        step();
        tests++;
        if (n !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: n=%h out_valid=%b busy=%b want 0/0/0", n, out_valid, busy);
        end
        reset = 1'b0;
        step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_immediate();
        logic [2:0]  sels[5];
        logic [31:0] exps[5];
        sels = '{3'd1, 3'd3, 3'd7, 3'd0, 3'd2};
        exps = '{32'hFFFFFFB0, 32'h823B0800, 32'h0, 32'h8431FFEB, 32'h00002761};
        for (int i = 0; i < 5; i++) begin
            drive(sels[i], 32'h8431FFEB, 21'h104761, 1'b0, 5'd0);
            step();
            scramble();
            tests++;
            if (out_valid !== 1'b1 || n !== exps[i]) begin
                fails++;
                $display("FAIL imm_sel%0d: out_valid=%b n=%h want 1 %h", sels[i], out_valid, n,
                         exps[i]);
            end
            consume();
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL imm_idle_sel%0d: out_valid=%b busy=%b want 0 0", sels[i],
                         out_valid, busy);
            end
        end
    endtask

    task automatic test_shift_directed();
        logic [2:0]  sels[5];
        logic [31:0] exps[5];
        logic [4:0]  sars[5];
        int          lats[5];
        sels = '{3'd4, 3'd5, 3'd6, 3'd4, 3'd5};
        exps = '{32'h08431FFE, 32'hF8431FFE, 32'h431FFEB0, 32'h00000843, 32'hFFFFF843};
        sars = '{5'd0, 5'd0, 5'd0, 5'd11, 5'd11};
        lats = '{1, 1, 1, 3, 3};
        for (int i = 0; i < 5; i++) begin
            drive(sels[i], 32'h8431FFEB, 21'h104761, (i >= 3), sars[i]);
            step();
            scramble();
            for (int k = 0; k < lats[i]; k++) begin
                tests++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL shift%0d_busy cyc%0d: out_valid=%b in_ready=%b busy=%b want 0 0 1",
                             i, k, out_valid, in_ready, busy);
                end
                step();
            end
            tests++;
            if (out_valid !== 1'b1 || n !== exps[i]) begin
                fails++;
                $display("FAIL shift%0d_result: out_valid=%b n=%h want 1 %h", i, out_valid, n,
                         exps[i]);
            end
            consume();
        end
    endtask

    task automatic test_boundary();
        int cyc;
        // sar=0 -> maximal shift of WIDTH-1
        drive(3'd5, 32'h8000_0000, 21'h0, 1'b1, 5'd0);
        step();
        scramble();
        wait_valid(20, cyc);
        tests++;
        if (cyc !== 4 || n !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL amt31: latency=%0d n=%h want 4 ffffffff", cyc, n);
        end
        consume();
        // sar=31 -> zero shift, no SHIFT cycles
        drive(3'd6, 32'hCAFE1234, 21'h0, 1'b1, 5'd31);
        step();
        scramble();
        tests++;
        if (out_valid !== 1'b1 || n !== 32'hCAFE1234) begin
            fails++;
            $display("FAIL amt0: out_valid=%b n=%h want 1 cafe1234", out_valid, n);
        end
        consume();
    endtask

    task automatic test_backpressure();
        drive(3'd1, 32'h8431FFEB, 21'h104761, 1'b0, 5'd0);
        step();
        scramble();
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (out_valid !== 1'b1 || n !== 32'hFFFFFFB0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold cyc%0d: out_valid=%b n=%h in_ready=%b want 1 ffffffb0 0", k,
                         out_valid, n, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        drive(3'd0, 32'h12345678, 21'h0, 1'b0, 5'd0);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        step();
        scramble();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || n !== 32'h12345678) begin
            fails++;
            $display("FAIL same_edge_accept: out_valid=%b n=%h want 1 12345678", out_valid, n);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_n = $urandom;
            drive(3'd0, exp_n, 21'($urandom), 1'b0, 5'd0);
            step();
            tests++;
            if (out_valid !== 1'b1 || n !== exp_n) begin
                fails++;
                $display("FAIL stream%0d: out_valid=%b n=%h want 1 %h", i, out_valid, n, exp_n);
            end
        end
        scramble();
        step();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        drive(3'd4, 32'h8431FFEB, 21'h104761, 1'b1, 5'd11);
        step();
        scramble();
        step();
        reset = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || n !== 32'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: out_valid=%b n=%h busy=%b want 0 0 0", out_valid, n, busy);
        end
        step();
        reset = 1'b0;
        step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready: got %b want 1", in_ready);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL stale_result: out_valid high %0d cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [2:0]  s;
        logic [31:0] b;
        logic [20:0] im;
        logic        us;
        logic [4:0]  sr;
        logic [31:0] exp_n;
        int          exp_lat;
        int          cyc;
        for (int i = 0; i < 60; i++) begin
            s       = 3'($urandom);
            b       = $urandom;
            im      = 21'($urandom);
            us      = 1'($urandom);
            sr      = 5'($urandom);
            exp_n   = model_n(s, b, im, us, sr);
            exp_lat = model_lat(s, im, us, sr);
            drive(s, b, im, us, sr);
            step();
            scramble();
            wait_valid(20, cyc);
            tests++;
            if (cyc != exp_lat || n !== exp_n) begin
                fails++;
                $display("FAIL rand%0d sel=%0d rb=%h imm=%h use_sar=%b sar=%0d: lat=%0d n=%h want %0d %h",
                         i, s, b, im, us, sr, cyc, n, exp_lat, exp_n);
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_shift_directed();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_handler_seq.md
Name: operand_handler_seq

Overview:
- Parametrised, multi-cycle successor to the combinational operand handler that feeds the ALU's B operand.
- Produces the same seven operand forms: pass-through, two low-sign-extends, left-immediate, and three shifts.
- Adds width generality, a register (SAR) shift-amount source, and an iterative shifter of STEP bits per cycle.
- Sits between register read and the ALU, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: datapath width; 32 or 64.
- IMM_W, 21: immediate field width; constraint IMM_W >= max(14, 5+AW), IMM_W <= WIDTH.
- STEP, 8: maximum bits shifted per cycle; power of 2, 1 <= STEP <= WIDTH.
- AW, $clog2(WIDTH): shift-amount width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- rb  in  WIDTH  register operand.
- imm  in  IMM_W  immediate field.
- sel  in  3  operation select (encodings below).
- use_sar  in  1  1: shift amount taken from sar; 0: taken from imm.
- sar  in  AW  shift-amount register value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- n  out  WIDTH  result.
- busy  out  1  FSM not in IDLE.

Behaviour:
- sel encodings:
  - 0: n = rb.
  - 1: low-sign-extend 11, i.e. {sext(imm[10]), imm[0], imm[10:1]}.
  - 2: low-sign-extend 14, i.e. {sext(imm[13]), imm[0], imm[12:0]}.
  - 3: n = imm << (WIDTH-IMM_W).
  - 4: SRL. 5: SRA. 6: SLL.
  - 7: n = 0.
- Shift amount: amt = (WIDTH-1) - F, mod 2^AW. F = sar if use_sar, else imm[5 +: AW].
- All fields are captured on acceptance; later input changes have no effect.
- FSM states are IDLE, SHIFT, DONE.
- Acceptance happens at an edge with in_valid && in_ready (edge E0).
  - sel in {0,1,2,3,7}, or a shift with amt == 0: result is computed combinationally and loaded; go to DONE. out_valid = 1 after E0.
  - sel in {4,5,6} with amt > 0: load rb, rem = amt, latch sign = rb[WIDTH-1]; go to SHIFT.
- SHIFT state, each edge:
  - Shift the data by s = min(rem, STEP) and set rem -= s.
  - SRA fills with the latched sign; SRL and SLL fill with 0.
  - When rem becomes 0, go to DONE.
  - out_valid is first high after edge E0 + ceil(amt/STEP).
- DONE state:
  - n and out_valid are held stable while out_ready = 0.
  - On an edge with out_ready = 1: if a new request is accepted the same edge, follow the acceptance rules; else go to IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This gives back-to-back throughput of one immediate-mode op per cycle.
- busy = (state != IDLE). in_ready is low throughout SHIFT.
- Reset (any time, including mid-SHIFT or in DONE with an unconsumed result):
  - state = IDLE, n = 0, out_valid = 0, busy = 0, rem = 0.
  - The in-flight op is discarded.
  - in_ready = 1 from the first cycle after reset deasserts.
- Boundary: amt = WIDTH-1 with STEP = 1 takes WIDTH-1 SHIFT cycles, and rem never underflows.

Decomposition:
- Package operand_handler_pkg holds:
  - SEL_* localparams: SEL_PASS=0, SEL_LSE11=1, SEL_LSE14=2, SEL_LIMM=3, SEL_SRL=4, SEL_SRA=5, SEL_SLL=6, SEL_ZERO=7.
  - The state enum (IDLE/SHIFT/DONE).
- One sub-module, operand_step_shifter: combinational, shifts data by an s in 0..STEP, with a direction input and an arith-fill input.
- The top level holds the FSM, the rem counter, the immediate formatting, and the output register.

Test Plan:
- Defaults apply (WIDTH=32, IMM_W=21, STEP=8); rb=0x8431FFEB, imm=21'h104761, use_sar=0, so F=27 and amt=4.
  - sel=1 -> n=0xFFFFFFB0, out_valid after E0.
  - sel=3 -> n=0x823B0800.
  - sel=7 -> n=0.
- Shifts, same stimulus with amt=4 (one SHIFT cycle, out_valid after E0+1):
  - sel=4 -> 0x08431FFE.
  - sel=5 -> 0xF8431FFE.
  - sel=6 -> 0x431FFEB0.
- Multi-step: use_sar=1, sar=11, so amt=20.
  - sel=4 -> n=0x00000843, out_valid after E0+3, in_ready=0 and busy=1 during the 3 SHIFT cycles.
  - sel=5 -> 0xFFFFF843.
- Backpressure and throughput:
  - Hold out_ready=0 for 5 cycles after a result -> n and out_valid stable, in_ready=0.
  - Then drive out_ready=1 with a new sel=0, rb=0x12345678 already valid -> accepted the same edge; next result 0x12345678 after the following edge.
  - Streaming four sel=0 ops with out_ready=1 -> one result per cycle.
- Reset mid-SHIFT: assert reset during the second cycle of an amt=20 op -> out_valid=0, n=0, busy=0 immediately (asynchronous); no stale result ever appears.
- use_sar with F=31 (amt=0), sel=6 -> n=rb after E0, with no SHIFT cycles.
